// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int A     = $clog2(NREGS);

  typedef logic [A-1:0]    reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set on issue, cleared by writeback or flush.
// Set beats clear on the same register; flush beats set. Bit 0 is never pending.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int A     = $clog2(NREGS),
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set,
  input  logic [A-1:0] set_addr,
  input  logic [NWR-1:0] clr_en,
  input  logic [A-1:0] clr_addr [NWR],
  input  logic         flush,
  input  logic [A-1:0] look_addr [NRD],
  output logic [NRD-1:0] busy
);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;

  always_comb begin
    pending_nxt = pending;
    for (int p = 0; p < NWR; p++) begin
      if (clr_en[p] && (clr_addr[p] != '0)) pending_nxt[clr_addr[p]] = 1'b0;
    end
    if (flush) begin
      pending_nxt = '0;
    end else if (set && (set_addr != '0)) begin
      pending_nxt[set_addr] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_look
    assign busy[i] = pending[look_addr[i]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional same-cycle write bypass and an issue scoreboard.
// x0 is hard-wired zero: never stored, never pending, always reads 0.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = regfile_pkg::XLEN,
  parameter int NREGS  = regfile_pkg::NREGS,
  parameter int A      = $clog2(NREGS),
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [A-1:0]    rd_addr [NRD],
  output logic [XLEN-1:0] rd_data [NRD],
  output logic [NRD-1:0]  rd_busy,
  input  logic [NWR-1:0]  we,
  input  logic [A-1:0]    wa [NWR],
  input  logic [XLEN-1:0] wd [NWR],
  input  logic            sb_set,
  input  logic [A-1:0]    sb_addr,
  input  logic            flush
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NRD-1:0]  sb_busy;

  // Later ports are applied last so port 1 wins a same-address conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (we[p] && (wa[p] != '0)) regs[wa[p]] <= wd[p];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .A     (A),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set       (sb_set),
    .set_addr  (sb_addr),
    .clr_en    (we),
    .clr_addr  (wa),
    .flush     (flush),
    .look_addr (rd_addr),
    .busy      (sb_busy)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    always_comb begin
      rd_data[i] = regs[rd_addr[i]];
      rd_busy[i] = sb_busy[i];
      if (BYPASS != 0) begin
        for (int p = 0; p < NWR; p++) begin
          if (we[p] && (wa[p] == rd_addr[i])) begin
            rd_data[i] = wd[p];
            rd_busy[i] = 1'b0;
          end
        end
      end
      if (rd_addr[i] == '0) begin
        rd_data[i] = '0;
        rd_busy[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: two register files (bypass/2 write ports, no-bypass/1 write port) share stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rd_addr [2];
  logic [31:0] rd_data0 [2];
  logic [31:0] rd_data1 [2];
  logic [1:0]  rd_busy0;
  logic [1:0]  rd_busy1;
  logic [1:0]  we;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        flush;

  logic [0:0]  we1;
  logic [4:0]  wa1 [1];
  logic [31:0] wd1 [1];
  assign we1[0] = we[0];
  assign wa1[0] = wa[0];
  assign wd1[0] = wd[0];

  always #5 clk = ~clk;

  regfile_mp #(.NRD(2), .NWR(2), .BYPASS(1)) dut0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush)
  );

  regfile_mp #(.NRD(2), .NWR(1), .BYPASS(0)) dut1 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .we(we1), .wa(wa1), .wd(wd1), .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush)
  );

  typedef struct {
    int          dut;
    int          port;
    logic [31:0] d;
    logic        b;
    string       name;
  } exp_t;

  exp_t exp_q [$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: read ports are combinational, so each negedge presents a result for every queued expectation.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] ad;
      logic        ab;
      e = exp_q.pop_front();
      if (e.dut == 0) begin ad = rd_data0[e.port]; ab = rd_busy0[e.port]; end
      else            begin ad = rd_data1[e.port]; ab = rd_busy1[e.port]; end
      total++;
      if (ad !== e.d || ab !== e.b) begin
        bad++;
        $display("FAIL %s dut%0d port%0d: got data=%h busy=%b, want data=%h busy=%b",
                 e.name, e.dut, e.port, ad, ab, e.d, e.b);
      end
    end
  end

  task automatic expect_rd(input int dut, input int port, input logic [31:0] d,
                           input logic b, input string name);
    exp_t e;
    e.dut = dut; e.port = port; e.d = d; e.b = b; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic expect_both(input int port, input logic [31:0] d, input logic b, input string name);
    expect_rd(0, port, d, b, name);
    expect_rd(1, port, d, b, name);
  endtask

  // Advance to just after a rising edge and return all control inputs to idle.
  task automatic step();
    @(posedge clk);
    #1;
    we = 2'b00; sb_set = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rd_addr[0] = '0; rd_addr[1] = '0;
    we = '0; wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
    sb_set = 1'b0; sb_addr = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      step();
      rd_addr[0] = 5'(i); rd_addr[1] = 5'(31 - i);
      expect_both(0, 32'h0, 1'b0, "reset_p0");
      expect_both(1, 32'h0, 1'b0, "reset_p1");
    end

    step();
    we = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF; rd_addr[0] = 5'd5; rd_addr[1] = 5'd6;
    expect_rd(0, 0, 32'hDEAD_BEEF, 1'b0, "bypass_same_cycle");
    expect_rd(1, 0, 32'h0, 1'b0, "nobypass_old_value");
    step();
    expect_both(0, 32'hDEAD_BEEF, 1'b0, "write_stored");

    step();
    we = 2'b01; wa[0] = 5'd0; wd[0] = 32'hFFFF_FFFF; sb_set = 1'b1; sb_addr = 5'd0;
    rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
    expect_both(0, 32'h0, 1'b0, "x0_write_cycle");
    step();
    expect_both(0, 32'h0, 1'b0, "x0_after_p0");
    expect_both(1, 32'h0, 1'b0, "x0_after_p1");

    step();
    we = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 32'h1; wd[1] = 32'h2; rd_addr[0] = 5'd7;
    expect_rd(0, 0, 32'h2, 1'b0, "conflict_bypass");
    expect_rd(1, 0, 32'h0, 1'b0, "conflict_nobypass_old");
    step();
    expect_rd(0, 0, 32'h2, 1'b0, "conflict_port1_wins");
    expect_rd(1, 0, 32'h1, 1'b0, "single_port_write");

    step();
    sb_set = 1'b1; sb_addr = 5'd9; rd_addr[0] = 5'd9;
    expect_both(0, 32'h0, 1'b0, "sb_set_not_yet");
    step();
    sb_set = 1'b1; sb_addr = 5'd9; we = 2'b01; wa[0] = 5'd9; wd[0] = 32'h99;
    expect_rd(0, 0, 32'h99, 1'b0, "sb_bypass_clears_busy");
    expect_rd(1, 0, 32'h0, 1'b1, "sb_busy_after_set");
    step();
    we = 2'b01; wa[0] = 5'd9; wd[0] = 32'hAA;
    expect_rd(0, 0, 32'hAA, 1'b0, "sb_bypass_write_only");
    expect_rd(1, 0, 32'h99, 1'b1, "sb_set_beats_clear");
    step();
    expect_both(0, 32'hAA, 1'b0, "sb_cleared_by_write");

    step();
    sb_set = 1'b1; sb_addr = 5'd3;
    step();
    sb_set = 1'b1; sb_addr = 5'd4;
    step();
    sb_set = 1'b1; sb_addr = 5'd10; rd_addr[0] = 5'd3; rd_addr[1] = 5'd4;
    expect_both(0, 32'h0, 1'b1, "pend_r3");
    expect_both(1, 32'h0, 1'b1, "pend_r4");
    step();
    flush = 1'b1; sb_set = 1'b1; sb_addr = 5'd11; rd_addr[0] = 5'd10; rd_addr[1] = 5'd11;
    expect_both(0, 32'h0, 1'b1, "pend_r10");
    expect_both(1, 32'h0, 1'b0, "pend_r11_before");
    step();
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd4;
    expect_both(0, 32'h0, 1'b0, "flush_r3");
    expect_both(1, 32'h0, 1'b0, "flush_r4");
    step();
    rd_addr[0] = 5'd10; rd_addr[1] = 5'd11;
    expect_both(0, 32'h0, 1'b0, "flush_r10");
    expect_both(1, 32'h0, 1'b0, "flush_beats_set");

    step();
    we = 2'b01; wa[0] = 5'd12; wd[0] = 32'h1234; sb_set = 1'b1; sb_addr = 5'd13;
    step();
    rd_addr[0] = 5'd12; rd_addr[1] = 5'd13;
    expect_both(0, 32'h1234, 1'b0, "pre_rst_data");
    expect_both(1, 32'h0, 1'b1, "pre_rst_busy");
    step();
    rd_addr[0] = 5'd12; rd_addr[1] = 5'd5;
    #2 rst = 1'b1;
    expect_both(0, 32'h0, 1'b0, "rst_async_r12");
    expect_both(1, 32'h0, 1'b0, "rst_async_r5");
    step();
    rst = 1'b0;
    rd_addr[1] = 5'd13;
    expect_both(0, 32'h0, 1'b0, "post_rst_r12");
    expect_both(1, 32'h0, 1'b0, "post_rst_busy13");

    step();
    step();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core, with configurable read/write port count, optional same-cycle write-to-read bypass and a per-register pending scoreboard for pipelined issue. It sits between decode/issue (read ports, scoreboard set) and writeback (write ports, scoreboard clear). Register 0 reads as zero and is never written or marked pending.

## Interface
- XLEN, 32: data width of each register.
- NREGS, 32: number of architectural registers (power of two, ≥ 2).
- A, $clog2(NREGS): address width (derived).
- NRD, 2: number of read ports (1..4).
- NWR, 1: number of write ports (1..2).
- BYPASS, 1: 1 = read ports return same-cycle write data; 0 = reads return stored value only.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NRD×A  read addresses.
- rd_data  out  NRD×XLEN  read data (combinational).
- rd_busy  out  NRD  pending bit of addressed register (combinational).
- we  in  NWR  write enables.
- wa  in  NWR×A  write addresses.
- wd  in  NWR×XLEN  write data.
- sb_set  in  1  mark register sb_addr pending (instruction issued).
- sb_addr  in  A  register to mark pending.
- flush  in  1  clear all pending bits (pipeline flush).

## Operation
- Reset: all registers 0, all pending bits 0; rd_data follows stored zeros, rd_busy 0.
- Write: on posedge, for each port p with we[p] and wa[p] ≠ 0, reg[wa[p]] ← wd[p] and pending[wa[p]] ← 0.
- Write conflict (NWR = 2, both enabled, same non-zero address): port 1 wins for data; pending cleared once.
- Writes to address 0: ignored entirely (data and scoreboard).
- Scoreboard set: on posedge, if sb_set and sb_addr ≠ 0, pending[sb_addr] ← 1.
- Set and writeback clear on same register same cycle: set wins (pending = 1 afterwards; data still written).
- flush: on posedge all pending bits ← 0; flush beats sb_set in the same cycle; writes still proceed normally.
- Read, BYPASS=1: if any enabled write port targets rd_addr[i] (≠ 0) this cycle, rd_data[i] = that wd (highest-index port wins), rd_busy[i] = 0; else stored value and stored pending bit.
- Read, BYPASS=0: rd_data[i] = stored reg, rd_busy[i] = stored pending bit.
- rd_addr[i] = 0: rd_data[i] = 0, rd_busy[i] = 0 regardless of writes.

## Timing
- Write latency: 1 cycle to storage; 0 cycles to read ports when BYPASS=1.
- Scoreboard set/clear visible on rd_busy the cycle after the edge that applied it.
- Reads purely combinational from addresses and write-port inputs; no registered outputs.
- rst asserted mid-operation: state cleared immediately, independent of clk; writes/sets in that cycle lost.
- Deassertion of rst synchronous to clk is required of the integrator; the block itself does not synchronise.

## Structure
- Shared package regfile_pkg: XLEN, NREGS constants, typedef reg_addr_t (logic [A-1:0]), typedef xlen_t (logic [XLEN-1:0]).
- Sub-module regfile_scoreboard: NREGS pending bits with set, per-write-port clear, flush, and NRD combinational lookups; the top holds data storage, bypass muxes and x0 masking.
- Read/write ports expressed as unpacked arrays indexed by port; generate loops over NRD/NWR.

## Test plan
- Reset then read all addresses on both ports -> rd_data = 0, rd_busy = 0 for every register.
- we[0]=1, wa=5, wd=32'hDEAD_BEEF with rd_addr[0]=5, BYPASS=1 -> rd_data[0]=32'hDEAD_BEEF same cycle; BYPASS=0 -> old value, then 32'hDEAD_BEEF next cycle.
- Write wa=0, wd=32'hFFFF_FFFF; sb_set with sb_addr=0 -> reading x0 gives 0, rd_busy 0.
- NWR=2, both ports write reg 7 with 32'h1 and 32'h2 -> reg 7 = 32'h2 next cycle.
- sb_set on reg 9, next cycle rd_busy=1; then sb_set reg 9 plus write reg 9 same cycle -> rd_busy stays 1; then write only -> rd_busy 0.
- Set pending on regs 3, 4, 10; assert flush together with sb_set reg 11 -> all rd_busy 0 next cycle; assert rst mid-sequence -> all data 0 immediately.
